// File: rtl/viterbi_frame_encoder.sv
// Framed rate-1/2 convolutional encoder: bytes in over valid/ready, one coded
// symbol per cycle out (MSB first), terminated by K-1 zero tail symbols.
//
// state   | meaning
// S_IDLE  | no frame; ready for the first byte
// S_SHIFT | emitting data symbols of the latched byte
// S_WAIT  | mid-frame, starved for the next byte; encoder state held
// S_TAIL  | flushing K-1 zero bits to return the trellis to state 0
module viterbi_frame_encoder #(
  parameter int unsigned  FRAME_BYTES = 4,
  parameter int unsigned  K           = 3,
  parameter logic [K-1:0] G0          = 3'b111,
  parameter logic [K-1:0] G1          = 3'b101
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] byte_i,
  input  logic       byte_valid_i,
  output logic       byte_ready_o,
  output logic       valid_o,
  output logic [1:0] d_out,
  output logic       sop_o,
  output logic       eop_o,
  output logic       busy_o
);

  localparam int unsigned SRW = K - 1;
  localparam int unsigned BCW = $clog2(FRAME_BYTES + 1);
  localparam int unsigned TCW = $clog2(K);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_WAIT, S_TAIL} state_t;

  state_t           state_q, state_d;
  logic [SRW-1:0]   sr_q, sr_d;
  logic [7:0]       byte_q, byte_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [BCW-1:0]   byte_cnt_q, byte_cnt_d;
  logic [TCW-1:0]   tail_cnt_q, tail_cnt_d;
  logic             valid_q, valid_d;
  logic [1:0]       d_out_q, d_out_d;
  logic             sop_q, sop_d;
  logic             eop_q, eop_d;
  logic             ready;

  logic             in_bit;
  logic [K-1:0]     win;
  logic [1:0]       sym;
  logic [SRW-1:0]   sr_shift;

  // Window is {in, sr[0], ..., sr[K-2]} with sr[0] the most recent bit.
  always_comb begin
    in_bit = (state_q == S_SHIFT) ? byte_q[bit_idx_q] : 1'b0;
    win = '0;
    win[K-1] = in_bit;
    for (int j = 0; j < int'(SRW); j++) begin
      win[K-2-j] = sr_q[j];
    end
    sym      = {^(win & G0), ^(win & G1)};
    sr_shift = SRW'({sr_q, in_bit});
  end

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    byte_d     = byte_q;
    bit_idx_d  = bit_idx_q;
    byte_cnt_d = byte_cnt_q;
    tail_cnt_d = tail_cnt_q;
    valid_d    = 1'b0;
    d_out_d    = 2'b00;
    sop_d      = 1'b0;
    eop_d      = 1'b0;
    ready      = 1'b0;

    case (state_q)
      S_IDLE: begin
        ready = 1'b1;
        if (byte_valid_i) begin
          byte_d     = byte_i;
          byte_cnt_d = BCW'(1);
          bit_idx_d  = 3'd7;
          state_d    = S_SHIFT;
        end
      end
      S_SHIFT: begin
        valid_d   = 1'b1;
        d_out_d   = sym;
        sop_d     = (byte_cnt_q == BCW'(1)) && (bit_idx_q == 3'd7);
        sr_d      = sr_shift;
        bit_idx_d = bit_idx_q - 3'd1;
        if (bit_idx_q == 3'd0) begin
          if (byte_cnt_q < BCW'(FRAME_BYTES)) begin
            ready = 1'b1;
            if (byte_valid_i) begin
              byte_d     = byte_i;
              byte_cnt_d = byte_cnt_q + BCW'(1);
              bit_idx_d  = 3'd7;
            end else begin
              state_d = S_WAIT;
            end
          end else begin
            tail_cnt_d = TCW'(K - 1);
            state_d    = S_TAIL;
          end
        end
      end
      S_WAIT: begin
        ready = 1'b1;
        if (byte_valid_i) begin
          byte_d     = byte_i;
          byte_cnt_d = byte_cnt_q + BCW'(1);
          bit_idx_d  = 3'd7;
          state_d    = S_SHIFT;
        end
      end
      S_TAIL: begin
        valid_d    = 1'b1;
        d_out_d    = sym;
        sr_d       = sr_shift;
        tail_cnt_d = tail_cnt_q - TCW'(1);
        if (tail_cnt_q == TCW'(1)) begin
          eop_d      = 1'b1;
          byte_cnt_d = '0;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      sr_q       <= '0;
      byte_q     <= '0;
      bit_idx_q  <= '0;
      byte_cnt_q <= '0;
      tail_cnt_q <= '0;
      valid_q    <= 1'b0;
      d_out_q    <= 2'b00;
      sop_q      <= 1'b0;
      eop_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      byte_q     <= byte_d;
      bit_idx_q  <= bit_idx_d;
      byte_cnt_q <= byte_cnt_d;
      tail_cnt_q <= tail_cnt_d;
      valid_q    <= valid_d;
      d_out_q    <= d_out_d;
      sop_q      <= sop_d;
      eop_q      <= eop_d;
    end
  end

  assign byte_ready_o = ready;
  assign busy_o       = (state_q != S_IDLE);
  assign valid_o      = valid_q;
  assign d_out        = d_out_q;
  assign sop_o        = sop_q;
  assign eop_o        = eop_q;

endmodule

// File: tb/tb_viterbi_frame_encoder.sv
// Directed bench for viterbi_frame_encoder: a 1-byte-frame instance for
// hand-computed symbol tables, a 4-byte-frame instance for framing scenarios.
module tb_viterbi_frame_encoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 1-byte frame instance
  logic       rst1, v1, rdy1, valid1, sop1, eop1, busy1;
  logic [7:0] b1;
  logic [1:0] dout1;

  // 4-byte frame instance
  logic       rst4, v4, rdy4, valid4, sop4, eop4, busy4;
  logic [7:0] b4;
  logic [1:0] dout4;

  viterbi_frame_encoder #(.FRAME_BYTES(1)) dut1 (
    .clk(clk), .rst(rst1), .byte_i(b1), .byte_valid_i(v1), .byte_ready_o(rdy1),
    .valid_o(valid1), .d_out(dout1), .sop_o(sop1), .eop_o(eop1), .busy_o(busy1)
  );

  viterbi_frame_encoder #(.FRAME_BYTES(4)) dut4 (
    .clk(clk), .rst(rst4), .byte_i(b4), .byte_valid_i(v4), .byte_ready_o(rdy4),
    .valid_o(valid4), .d_out(dout4), .sop_o(sop4), .eop_o(eop4), .busy_o(busy4)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // feeder for dut4: presents queued bytes, optional valid gap after the first byte
  logic [7:0] feed_q[$];
  int         gap_req  = 0;
  int         gap_cnt  = 0;
  logic       acc_pend = 1'b0;

  initial begin : feeder
    v4 = 1'b0;
    b4 = 8'h00;
    forever begin
      @(negedge clk);
      if (acc_pend && feed_q.size() > 0) begin
        void'(feed_q.pop_front());
        if (gap_req > 0) begin
          gap_cnt = gap_req;
          gap_req = 0;
        end
      end
      if (gap_cnt > 0) begin
        gap_cnt--;
        v4 = 1'b0;
      end else if (feed_q.size() > 0) begin
        v4 = 1'b1;
        b4 = feed_q[0];
      end else begin
        v4 = 1'b0;
      end
      acc_pend = v4 && rdy4 && rst4;
    end
  end

  // monitor for dut4: records {sop,eop,d_out} of every valid symbol
  logic [3:0] sym_q[$];
  int   n_sop = 0, n_eop = 0, gap_in_frame = 0, inter_gap = 0, inter_gap_seen = -1;
  logic in_frame = 1'b0, after_eop = 1'b0;

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (valid4) begin
        sym_q.push_back({sop4, eop4, dout4});
        if (sop4) begin
          n_sop++;
          in_frame = 1'b1;
          if (after_eop) inter_gap_seen = inter_gap;
          after_eop = 1'b0;
        end
        if (eop4) begin
          n_eop++;
          in_frame  = 1'b0;
          after_eop = 1'b1;
          inter_gap = 0;
        end
      end else begin
        if (in_frame) gap_in_frame++;
        if (after_eop) inter_gap++;
      end
    end
  end

  task automatic clr_mon();
    sym_q.delete();
    n_sop = 0; n_eop = 0; gap_in_frame = 0;
    inter_gap = 0; inter_gap_seen = -1;
    in_frame = 1'b0; after_eop = 1'b0;
  endtask

  // bit-serial reference for K=3, G0=111, G1=101; starts each frame from state 0
  logic [1:0] exp_q[$];

  task automatic build_exp(input logic [7:0] a0, input logic [7:0] a1,
                           input logic [7:0] a2, input logic [7:0] a3);
    logic [31:0] bits;
    logic [1:0]  s;
    logic        x;
    bits = {a0, a1, a2, a3};
    s = 2'b00;
    for (int i = 0; i < 34; i++) begin
      x = (i < 32) ? bits[31-i] : 1'b0;
      exp_q.push_back({x ^ s[0] ^ s[1], x ^ s[1]});
      s = {s[0], x};
    end
  endtask

  task automatic cmp_stream(input string tag);
    logic [31:0] got;
    chk({tag, "_nsym"}, sym_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < sym_q.size()) ? {28'd0, sym_q[i]} : 32'hDEAD;
      chk($sformatf("%s_sym%0d", tag, i), got,
          {28'd0, (i % 34) == 0, (i % 34) == 33, exp_q[i]});
    end
  endtask

  task automatic wait_eops(input int n);
    for (int t = 0; t < 800 && n_eop < n; t++) @(negedge clk);
    repeat (2) @(negedge clk);
  endtask

  task automatic run_frame4(input string tag, input logic [7:0] a0, input logic [7:0] a1,
                            input logic [7:0] a2, input logic [7:0] a3, input int gap);
    clr_mon();
    exp_q.delete();
    build_exp(a0, a1, a2, a3);
    gap_req = gap;
    feed_q.push_back(a0); feed_q.push_back(a1);
    feed_q.push_back(a2); feed_q.push_back(a3);
    wait_eops(1);
    chk({tag, "_nsop"}, n_sop, 1);
    chk({tag, "_neop"}, n_eop, 1);
    chk({tag, "_gap"}, gap_in_frame, (gap > 0) ? 3 : 0);
    cmp_stream(tag);
  endtask

  // one 1-byte frame on dut1, checking every cycle against a hand table
  task automatic run_frame1(input string tag, input logic [7:0] b, input logic [19:0] syms);
    v1 = 1'b1; b1 = b;
    chk({tag, "_rdy_idle"}, rdy1, 1'b1);
    @(negedge clk);
    v1 = 1'b0;
    chk({tag, "_lat"}, {valid1, busy1}, 2'b01);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("%s_sym%0d", tag, i), {valid1, sop1, eop1, dout1},
          {1'b1, i == 0, i == 9, syms[19-2*i -: 2]});
    end
    chk({tag, "_rdy_eop"}, rdy1, 1'b1);
    @(negedge clk);
    chk({tag, "_after"}, {valid1, busy1, rdy1}, 3'b001);
  endtask

  initial begin : main
    rst1 = 1'b0; rst4 = 1'b0; v1 = 1'b0; b1 = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst1_outs", {valid1, sop1, eop1, dout1, busy1, rdy1}, 7'b0000001);
    chk("rst4_outs", {valid4, sop4, eop4, dout4, busy4, rdy4}, 7'b0000001);
    rst1 = 1'b1; rst4 = 1'b1;
    @(negedge clk);

    // 0xFF then 0x80: the second table only holds if the tail left sr at zero
    run_frame1("s2_ff", 8'hFF, {2'b11, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b11});
    run_frame1("s1_80", 8'h80, {2'b11, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00});

    run_frame4("s3", 8'hA5, 8'h3C, 8'h00, 8'hFF, 0);
    run_frame4("s4", 8'hA5, 8'h3C, 8'h00, 8'hFF, 10);

    // reset in the middle of a frame
    clr_mon();
    feed_q.push_back(8'hA5); feed_q.push_back(8'h3C);
    feed_q.push_back(8'h00); feed_q.push_back(8'hFF);
    for (int t = 0; t < 300 && sym_q.size() < 12; t++) @(negedge clk);
    chk("s5_reached12", sym_q.size() >= 12, 1'b1);
    rst4 = 1'b0;
    feed_q.delete();
    @(negedge clk);
    chk("s5_rst_outs", {valid4, sop4, eop4, dout4, busy4, rdy4}, 7'b0000001);
    rst4 = 1'b1;
    repeat (2) @(negedge clk);
    run_frame4("s5_new", 8'h80, 8'h11, 8'h22, 8'h33, 0);
    chk("s5_pre0", (sym_q.size() > 0) ? {28'd0, sym_q[0]} : 32'hDEAD, 32'hB);
    chk("s5_pre1", (sym_q.size() > 1) ? {28'd0, sym_q[1]} : 32'hDEAD, 32'h2);
    chk("s5_pre2", (sym_q.size() > 2) ? {28'd0, sym_q[2]} : 32'hDEAD, 32'h3);

    // back-to-back frames with byte_valid_i held high through the tail
    clr_mon();
    exp_q.delete();
    build_exp(8'hC3, 8'h5A, 8'h01, 8'h80);
    build_exp(8'h80, 8'hFF, 8'h00, 8'h96);
    feed_q.push_back(8'hC3); feed_q.push_back(8'h5A);
    feed_q.push_back(8'h01); feed_q.push_back(8'h80);
    feed_q.push_back(8'h80); feed_q.push_back(8'hFF);
    feed_q.push_back(8'h00); feed_q.push_back(8'h96);
    wait_eops(2);
    chk("s6_nsop", n_sop, 2);
    chk("s6_neop", n_eop, 2);
    chk("s6_gap", gap_in_frame, 0);
    chk("s6_idle_gap", inter_gap_seen, 1);
    cmp_stream("s6");
    chk("s6_idle", {busy4, rdy4, valid4}, 3'b010);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
